// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 channel multiplexer.
// The mode encoding matches the single-bit mode input of reg_mux_n.
package mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found scanning
// from ptr upwards, wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx
);

   always_comb begin
      int   idx;
      logic found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      if (en) begin
         for (int k = 0; k < N; k++) begin
            // ptr is always kept below N, so one subtraction wraps the scan
            idx = int'(ptr) + k;
            if (idx >= N) begin
               idx = idx - N;
            end
            if (!found && req[idx]) begin
               found        = 1'b1;
               gnt[idx]     = 1'b1;
               gnt_idx      = PW'(idx);
            end
         end
      end
   end

endmodule

// File: rtl/reg_mux_n.sv
// Registered N:1 channel multiplexer with valid/ready on every input and the
// output; channels are chosen by explicit select or by round-robin arbitration.
module reg_mux_n
   import mux_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic [SEL_W-1:0]    out_ch_q, out_ch_d;
   logic                out_valid_q, out_valid_d;
   logic [SEL_W-1:0]    ptr_q, ptr_d;

   logic                load_en;
   logic [CHANNELS-1:0] man_gnt;
   logic [CHANNELS-1:0] rr_gnt;
   logic [SEL_W-1:0]    rr_idx;
   logic [CHANNELS-1:0] grant;
   logic [SEL_W-1:0]    grant_idx;
   logic                transfer;
   logic [WIDTH-1:0]    grant_data;

   assign load_en = ~out_valid_q | out_ready;

   rr_arbiter #(
      .N  (CHANNELS),
      .PW (SEL_W)
   ) u_rr_arbiter (
      .req     (in_valid),
      .ptr     (ptr_q),
      .en      (mode == MODE_RR),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx)
   );

   // A select value beyond the last channel simply never grants
   always_comb begin
      man_gnt = '0;
      if (int'(sel) < CHANNELS) begin
         if (in_valid[sel]) begin
            man_gnt[sel] = 1'b1;
         end
      end
   end

   always_comb begin
      grant     = (mode == MODE_RR) ? rr_gnt : man_gnt;
      grant_idx = (mode == MODE_RR) ? rr_idx : sel;
      transfer  = (|grant) & load_en;
   end

   // Ready is forced low while reset is held, even though the register is empty
   assign in_ready = rst_n ? (grant & {CHANNELS{load_en}}) : '0;

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant[i]) begin
            grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (transfer) begin
         out_data_d  = grant_data;
         out_ch_d    = grant_idx;
         out_valid_d = 1'b1;
         if (mode == MODE_RR) begin
            ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
         end
      end else if (out_ready && out_valid_q) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_reg_mux_n.sv
// Self-checking bench for reg_mux_n: direct checks, a select table and a
// scoreboard of expected output words consumed as the DUT hands them over.
module tb_reg_mux_n;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic [1:0]  sel;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   logic        mode3;
   logic [1:0]  sel3;
   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_valid3;
   logic        out_ready3;

   typedef struct {
      logic [7:0] data;
      logic [1:0] ch;
   } word_t;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] valid;
      logic [3:0] exp_ready;
   } vec_t;

   word_t sb[$];
   vec_t  vecs[6];
   int    total;
   int    bad;

   reg_mux_n #(.WIDTH(8), .CHANNELS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   reg_mux_n #(.WIDTH(8), .CHANNELS(3)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode3),
      .sel       (sel3),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .out_data  (out_data3),
      .out_ch    (out_ch3),
      .out_valid (out_valid3),
      .out_ready (out_ready3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setData(input int ch, input logic [7:0] v);
      in_data[ch*8 +: 8] = v;
   endtask

   task automatic expectWord(input logic [7:0] d, input logic [1:0] c);
      word_t w;
      w.data = d;
      w.ch   = c;
      sb.push_back(w);
   endtask

   task automatic applyStimulus(input int k);
      mode     = 1'b0;
      sel      = vecs[k].sel;
      in_valid = vecs[k].valid;
      for (int i = 0; i < 4; i++) begin
         setData(i, 8'(8'h10 * (k + 1) + i));
      end
      if (vecs[k].exp_ready != 4'b0000) begin
         expectWord(8'(8'h10 * (k + 1) + vecs[k].sel), vecs[k].sel);
      end
   endtask

   // Consumer side: every accepted word must be the oldest expected one
   always @(negedge clk) begin
      word_t w;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sb_unexpected: got word %0h ch %0d expected none", out_data, out_ch);
         end else begin
            w = sb.pop_front();
            checkOutput("sb_data", 32'(out_data), 32'(w.data));
            checkOutput("sb_ch", 32'(out_ch), 32'(w.ch));
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      vecs[0] = '{sel: 2'd0, valid: 4'b0001, exp_ready: 4'b0001};
      vecs[1] = '{sel: 2'd1, valid: 4'b1101, exp_ready: 4'b0000};
      vecs[2] = '{sel: 2'd3, valid: 4'b1000, exp_ready: 4'b1000};
      vecs[3] = '{sel: 2'd2, valid: 4'b1011, exp_ready: 4'b0000};
      vecs[4] = '{sel: 2'd1, valid: 4'b1111, exp_ready: 4'b0010};
      vecs[5] = '{sel: 2'd2, valid: 4'b0000, exp_ready: 4'b0000};

      rst_n      = 1'b0;
      mode       = 1'b0;
      sel        = 2'd0;
      in_data    = '0;
      in_valid   = 4'b1111;
      out_ready  = 1'b0;
      mode3      = 1'b0;
      sel3       = 2'd0;
      in_data3   = '0;
      in_valid3  = 3'b000;
      out_ready3 = 1'b1;

      // Reset state, including ready gated low while reset is held
      #12;
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_out_data", 32'(out_data), 32'h0);
      checkOutput("rst_out_ch", 32'(out_ch), 32'h0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
      tick();
      in_valid = 4'b0000;
      rst_n    = 1'b1;
      tick();

      // Hold a word, then reset mid-stream: it must vanish immediately
      sel = 2'd2;
      in_valid = 4'b0100;
      setData(2, 8'h5A);
      tick();
      checkOutput("held_out_valid", 32'(out_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("midrst_out_data", 32'(out_data), 32'h0);
      checkOutput("midrst_out_ch", 32'(out_ch), 32'h0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'h0);
      #1;
      rst_n = 1'b1;
      setData(2, 8'hA5);
      expectWord(8'hA5, 2'd2);
      tick();
      checkOutput("post_rst_data", 32'(out_data), 32'hA5);
      checkOutput("post_rst_ch", 32'(out_ch), 32'h2);
      checkOutput("post_rst_valid", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      in_valid  = 4'b0000;
      tick();
      tick();

      // Manual gating: selected channel not valid means no grant
      sel      = 2'd1;
      in_valid = 4'b1101;
      #1;
      checkOutput("gate_in_ready", 32'(in_ready), 32'h0);
      tick();
      checkOutput("gate_out_valid", 32'(out_valid), 32'h0);

      // Out-of-range select on the 3-channel instance
      sel3      = 2'd3;
      in_valid3 = 3'b111;
      #1;
      checkOutput("ch3_sel3_ready", 32'(in_ready3), 32'h0);
      tick();
      checkOutput("ch3_sel3_valid", 32'(out_valid3), 32'h0);
      sel3 = 2'd2;
      #1;
      checkOutput("ch3_sel2_ready", 32'(in_ready3), 32'h4);
      in_valid3 = 3'b000;

      // Manual select table with the consumer always ready
      for (int k = 0; k < 6; k++) begin
         applyStimulus(k);
         #1;
         checkOutput($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vecs[k].exp_ready));
         tick();
      end
      in_valid = 4'b0000;
      tick();

      // Round-robin fairness: all valid, no bubbles
      mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         setData(i, 8'(8'hC0 + i));
      end
      in_valid = 4'b1111;
      expectWord(8'hC0, 2'd0);
      expectWord(8'hC1, 2'd1);
      expectWord(8'hC2, 2'd2);
      expectWord(8'hC3, 2'd3);
      expectWord(8'hC0, 2'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("rr_nobubble%0d", i), 32'(out_valid), 32'h1);
      end
      in_valid = 4'b0000;
      tick();

      // Skip and wrap: move ptr to 3, then channels 0 and 2 alternate
      in_valid = 4'b0100;
      expectWord(8'hC2, 2'd2);
      tick();
      in_valid = 4'b0101;
      expectWord(8'hC0, 2'd0);
      expectWord(8'hC2, 2'd2);
      expectWord(8'hC0, 2'd0);
      tick();
      tick();
      tick();
      in_valid = 4'b0000;
      tick();

      // Backpressure: held word stays put, then drain and reload on one edge
      mode      = 1'b0;
      sel       = 2'd1;
      out_ready = 1'b0;
      in_valid  = 4'b0010;
      setData(1, 8'h3C);
      expectWord(8'h3C, 2'd1);
      tick();
      setData(1, 8'h77);
      expectWord(8'h77, 2'd1);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'h0);
         checkOutput($sformatf("bp_out_data%0d", i), 32'(out_data), 32'h3C);
         checkOutput($sformatf("bp_out_valid%0d", i), 32'(out_valid), 32'h1);
         tick();
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 32'(in_ready), 32'h2);
      tick();
      checkOutput("bp_reload_data", 32'(out_data), 32'h77);
      checkOutput("bp_reload_valid", 32'(out_valid), 32'h1);
      in_valid = 4'b0000;
      tick();

      // Mode switch: ptr survives manual transfers
      for (int i = 0; i < 4; i++) begin
         setData(i, 8'(8'h50 + i));
      end
      mode     = 1'b1;
      in_valid = 4'b0010;
      expectWord(8'h51, 2'd1);
      tick();
      mode     = 1'b0;
      sel      = 2'd0;
      in_valid = 4'b1111;
      expectWord(8'h50, 2'd0);
      expectWord(8'h50, 2'd0);
      tick();
      tick();
      mode = 1'b1;
      expectWord(8'h52, 2'd2);
      expectWord(8'h53, 2'd3);
      tick();
      tick();
      in_valid = 4'b0000;
      tick();
      tick();

      checkOutput("sb_drained", 32'(sb.size()), 32'h0);
      checkOutput("final_out_valid", 32'(out_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
